// File: rtl/traffic_mode_ctrl.sv
// traffic_mode_ctrl: prioritised special-mode controller for the light sequencer.
// Mode 0 is NORMAL; mode k+1 is entered by req[k] and left by rel[k]. Higher
// indices preempt lower ones, and a release is held back until the mode has
// been dwelt in for MIN_DWELL cycles.
module traffic_mode_ctrl #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned MIN_DWELL   = 16,
  parameter int unsigned SYNC_STAGES = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_REQ-1:0]               i_req,
  input  logic [NUM_REQ-1:0]               i_rel,
  output logic [$clog2(NUM_REQ+1)-1:0]     o_mode,
  output logic [NUM_REQ:0]                 o_mode_oh,
  output logic                             o_chg,
  output logic                             o_busy
);

  localparam int unsigned MODE_W = $clog2(NUM_REQ + 1);
  localparam int unsigned CNT_W  = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
  localparam logic [CNT_W-1:0] DWELL = CNT_W'(MIN_DWELL);

  typedef enum logic {
    ST_NORMAL,
    ST_ACTIVE
  } state_t;

  state_t              state, state_nxt;
  logic [MODE_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_sat;
  logic                pend, pend_nxt;
  logic                chg;

  logic [NUM_REQ-1:0]  req_pipe [SYNC_STAGES];
  logic [NUM_REQ-1:0]  rel_pipe [SYNC_STAGES];
  logic [NUM_REQ-1:0]  rq, rl;

  logic                any_req, any_up, rl_k, dwell_met;
  logic [MODE_W-1:0]   top_req, top_up;
  logic [MODE_W-1:0]   mode_cur, mode_nxt;

  // Input synchroniser chain for request and release lines
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        req_pipe[s] <= '0;
        rel_pipe[s] <= '0;
      end
    end else begin
      req_pipe[0] <= i_req;
      rel_pipe[0] <= i_rel;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        req_pipe[s] <= req_pipe[s-1];
        rel_pipe[s] <= rel_pipe[s-1];
      end
    end
  end

  assign rq = req_pipe[SYNC_STAGES-1];
  assign rl = rel_pipe[SYNC_STAGES-1];

  // Priority search: highest request overall, highest request above the
  // current mode, and the release bit belonging to the current mode
  always_comb begin
    any_req = 1'b0;
    any_up  = 1'b0;
    top_req = '0;
    top_up  = '0;
    rl_k    = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (rq[j]) begin
        any_req = 1'b1;
        top_req = MODE_W'(j);
        if (MODE_W'(j) > idx) begin
          any_up = 1'b1;
          top_up = MODE_W'(j);
        end
      end
      if (MODE_W'(j) == idx) begin
        rl_k = rl[j];
      end
    end
  end

  // cnt saturates at DWELL, so equality is the same as cnt >= DWELL
  assign dwell_met = (cnt == DWELL);
  assign cnt_sat   = dwell_met ? cnt : cnt + CNT_W'(1);

  // Next-state logic: preemption, then release, then early-release latch
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    case (state)
      ST_NORMAL: begin
        if (any_req) begin
          state_nxt = ST_ACTIVE;
          idx_nxt   = top_req;
          cnt_nxt   = '0;
          pend_nxt  = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (any_up) begin
          idx_nxt  = top_up;
          cnt_nxt  = '0;
          pend_nxt = 1'b0;
        end else if ((rl_k || pend) && dwell_met) begin
          state_nxt = ST_NORMAL;
          cnt_nxt   = '0;
          pend_nxt  = 1'b0;
        end else begin
          if (rl_k) begin
            pend_nxt = 1'b1;
          end
          cnt_nxt = cnt_sat;
        end
      end
      default: begin
        state_nxt = ST_NORMAL;
        idx_nxt   = '0;
        cnt_nxt   = '0;
        pend_nxt  = 1'b0;
      end
    endcase
  end

  // Encoded mode for the current and next state
  always_comb begin
    mode_cur = (state     == ST_ACTIVE) ? idx     + MODE_W'(1) : '0;
    mode_nxt = (state_nxt == ST_ACTIVE) ? idx_nxt + MODE_W'(1) : '0;
  end

  // State register; change flag lands in the same cycle as the new mode
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_NORMAL;
      idx   <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
      chg   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      chg   <= (mode_nxt != mode_cur);
    end
  end

  // Output decode from the state register
  always_comb begin
    o_mode_oh           = '0;
    o_mode_oh[mode_cur] = 1'b1;
    o_mode              = mode_cur;
    o_chg               = chg;
    o_busy              = (state == ST_ACTIVE) && !dwell_met;
  end

endmodule

// File: tb/tb_traffic_mode_ctrl.sv
// Bench for traffic_mode_ctrl: two instances (dwell 4 / 1 sync stage and
// dwell 0 / 2 sync stages) share stimulus and are checked every cycle
// against an abstract mode model.
module tb_traffic_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req, rel;

  logic [1:0] mode_a, mode_b;
  logic [3:0] oh_a, oh_b;
  logic       chg_a, chg_b, busy_a, busy_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  traffic_mode_ctrl #(.NUM_REQ(3), .MIN_DWELL(4), .SYNC_STAGES(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_rel(rel),
    .o_mode(mode_a), .o_mode_oh(oh_a), .o_chg(chg_a), .o_busy(busy_a)
  );

  traffic_mode_ctrl #(.NUM_REQ(3), .MIN_DWELL(0), .SYNC_STAGES(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_rel(rel),
    .o_mode(mode_b), .o_mode_oh(oh_b), .o_chg(chg_b), .o_busy(busy_b)
  );

  // Reference model: per unit, current mode number, cycles held, a pending
  // release flag, and a delay line of the raw inputs.
  int         stages [2] = '{1, 2};
  int         mind   [2] = '{4, 0};
  int         m      [2];
  int         held   [2];
  bit         pend   [2];
  bit         exp_chg[2];
  logic [2:0] sreq   [2][2];
  logic [2:0] srel   [2][2];

  task automatic reset_model();
    for (int u = 0; u < 2; u++) begin
      m[u] = 0; held[u] = 0; pend[u] = 0; exp_chg[u] = 0;
      for (int s = 0; s < 2; s++) begin
        sreq[u][s] = '0;
        srel[u][s] = '0;
      end
    end
  endtask

  task automatic model_edge(int u, logic [2:0] rq_in, logic [2:0] rl_in);
    logic [2:0] rq, rl;
    int hi, k, old;
    rq  = sreq[u][stages[u]-1];
    rl  = srel[u][stages[u]-1];
    old = m[u];
    hi  = -1;
    for (int j = 0; j < 3; j++) if (rq[j]) hi = j;
    if (m[u] == 0) begin
      if (hi >= 0) begin
        m[u] = hi + 1; held[u] = 0; pend[u] = 0;
      end
    end else begin
      k = m[u] - 1;
      if (hi > k) begin
        m[u] = hi + 1; held[u] = 0; pend[u] = 0;
      end else if ((rl[k] || pend[u]) && held[u] >= mind[u]) begin
        m[u] = 0; pend[u] = 0;
      end else begin
        if (rl[k]) pend[u] = 1;
        held[u]++;
      end
    end
    exp_chg[u] = (m[u] != old);
    sreq[u][1] = sreq[u][0];
    srel[u][1] = srel[u][0];
    sreq[u][0] = rq_in;
    srel[u][0] = rl_in;
  endtask

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [1:0] mo;
    logic [3:0] oh;
    logic       c, b;
    for (int u = 0; u < 2; u++) begin
      if (u == 0) begin mo = mode_a; oh = oh_a; c = chg_a; b = busy_a; end
      else        begin mo = mode_b; oh = oh_b; c = chg_b; b = busy_b; end
      chk($sformatf("u%0d mode", u), {2'b00, mo}, 4'(m[u]));
      chk($sformatf("u%0d mode_oh", u), oh, 4'(1 << m[u]));
      chk($sformatf("u%0d chg", u), {3'b000, c}, {3'b000, exp_chg[u]});
      chk($sformatf("u%0d busy", u), {3'b000, b},
          {3'b000, (m[u] != 0) && (held[u] < mind[u])});
    end
  endtask

  // Drive inputs, advance the model, take one clock, then check
  task automatic step(logic [2:0] rq_v, logic [2:0] rl_v);
    req = rq_v;
    rel = rl_v;
    model_edge(0, rq_v, rl_v);
    model_edge(1, rq_v, rl_v);
    @(posedge clk);
    #1 check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(req, 3'b000);
  endtask

  // Reset asserted between edges; outputs must clear without a clock
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    reset_model();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    req = '0;
    rel = '0;
    reset_model();
    #2 check_all();
    chk("reset oh literal", oh_a, 4'b0001);
    #1 rst = 1'b0;

    // Single request pulse, dwell count, mode held without release
    step(3'b001, 3'b000);
    chk("t1 mode after E0", {2'b00, mode_a}, 4'd0);
    step(3'b000, 3'b000);
    chk("t1 oh after E1", oh_a, 4'b0010);
    chk("t1 chg after E1", {3'b000, chg_a}, 4'd1);
    idle(8);

    // Release back to NORMAL, re-enter, then an early release at cnt=1
    step(3'b000, 3'b001);
    idle(3);
    step(3'b001, 3'b000);
    step(3'b000, 3'b000);
    step(3'b000, 3'b001);
    idle(6);

    // Early release pending, then preempted by the top request
    step(3'b001, 3'b000);
    step(3'b000, 3'b000);
    step(3'b000, 3'b001);
    step(3'b100, 3'b000);
    idle(8);
    chk("t3 mode held", {2'b00, mode_a}, 4'd3);

    // Lower requests and foreign releases ignored in mode 3
    step(3'b001, 3'b010);
    step(3'b001, 3'b000);
    step(3'b001, 3'b010);
    idle(3);
    step(3'b000, 3'b100);
    idle(3);
    step(3'b011, 3'b000);
    step(3'b011, 3'b000);
    chk("t4 mode 2", {2'b00, mode_a}, 4'd2);
    idle(2);

    // Asynchronous reset mid-mode with request still held
    step(3'b010, 3'b000);
    mid_reset();
    chk("t5 reset oh literal", oh_a, 4'b0001);
    step(3'b010, 3'b000);
    step(3'b010, 3'b000);
    chk("t5 mode re-entered", {2'b00, mode_a}, 4'd2);
    idle(6);

    // Zero-dwell, two-stage unit: enter and leave mode 2
    step(3'b000, 3'b010);
    idle(4);
    step(3'b010, 3'b000);
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);
    chk("t6 mode 2 after 3 edges", {2'b00, mode_b}, 4'd2);
    step(3'b000, 3'b010);
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);
    chk("t6 mode 0 after 3 edges", {2'b00, mode_b}, 4'd0);

    // Randomised traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      step(r[2:0] & r[5:3] & r[8:6], r[11:9] & r[14:12]);
      if (r[20:15] == 6'd0) mid_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
